nios2_oci_dct_sequencer: RTL and testbench

- Sequences the OCI data/control trace (DCT) packing buffer.
- Accepts 2-bit trace codes from the CPU trace tap and packs them into a 30-bit buffer (15 entries) with a 4-bit fill count.
- Emits each full or flushed buffer as a 34-bit frame over a valid/ready handshake to the trace store.
- Drives test_ending/test_has_ended-style end-of-test flush and done signalling for the simulation monitor.

---
 rtl/nios2_oci_dct_sequencer.sv | 144 ++++++++++++++
 tb/tb_nios2_oci_dct_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/nios2_oci_dct_sequencer.sv
// -----------------------------------------------------------------------------
// nios2_oci_dct_sequencer
//
// Packs 2-bit CPU trace codes into a 15-entry (30-bit) buffer and ships each
// full or flushed buffer as a 34-bit {count, buffer} frame over a valid/ready
// handshake. An end-of-test flush drains any partial buffer and then parks the
// block in a sticky DONE state that only reset leaves.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   br_valid       trace code present this cycle
//   br_code        trace code (00 not-taken, 01 taken, 10 exception, 11 reserved)
//   br_stall       code not accepted this cycle; source must hold it
//   flush_req      end-of-test request, sampled every cycle
//   frame_valid    frame_data valid, held until accepted
//   frame_ready    consumer accepts the frame
//   frame_data     {count, buffer}
//   dct_buffer     live packing buffer (monitor view)
//   dct_count      live entry count (monitor view)
//   test_ending    flush in progress, not yet done
//   test_has_ended sticky done flag
//   err_reserved   sticky, set when a reserved code is accepted
// -----------------------------------------------------------------------------
module nios2_oci_dct_sequencer #(
    parameter int ENTRIES = 15,
    parameter int ENTRY_W = 2
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               br_valid,
    input  logic [ENTRY_W-1:0]                                 br_code,
    output logic                                               br_stall,
    input  logic                                               flush_req,
    output logic                                               frame_valid,
    input  logic                                               frame_ready,
    output logic [$clog2(ENTRIES+1)+ENTRIES*ENTRY_W-1:0]       frame_data,
    output logic [ENTRIES*ENTRY_W-1:0]                         dct_buffer,
    output logic [$clog2(ENTRIES+1)-1:0]                       dct_count,
    output logic                                               test_ending,
    output logic                                               test_has_ended,
    output logic                                               err_reserved
);

    localparam int BUF_W = ENTRIES * ENTRY_W;
    localparam int CNT_W = $clog2(ENTRIES + 1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_EMIT  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [BUF_W-1:0]   r_buffer, w_buffer_next, w_buffer_packed;
    logic [CNT_W-1:0]   r_count, w_count_next, w_count_packed;
    logic               r_flush_pending, w_flush_pending_next;
    logic               r_test_ending;
    logic               r_err_reserved, w_err_next;
    logic               w_accept;

    assign w_accept = br_valid && (r_state == ST_ACCUM);

    // Each slot takes the incoming code only when it is the next free slot;
    // every other slot keeps its value, so unused upper entries stay zero.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot
            assign w_buffer_packed[gi*ENTRY_W +: ENTRY_W] =
                (w_accept && (r_count == CNT_W'(gi))) ? br_code
                                                      : r_buffer[gi*ENTRY_W +: ENTRY_W];
        end
    endgenerate

    assign w_count_packed = r_count + CNT_W'(w_accept);

    always_comb begin
        w_state_next         = r_state;
        w_buffer_next        = r_buffer;
        w_count_next         = r_count;
        w_flush_pending_next = r_flush_pending;
        w_err_next           = r_err_reserved |
                               (w_accept && (br_code == {ENTRY_W{1'b1}}));
        case (r_state)
            ST_ACCUM: begin
                // The new entry is packed first; any flush then acts on the
                // resulting count.
                w_buffer_next = w_buffer_packed;
                w_count_next  = w_count_packed;
                if (w_count_packed == CNT_W'(ENTRIES)) begin
                    w_state_next = ST_EMIT;
                    if (flush_req) w_flush_pending_next = 1'b1;
                end else if (flush_req || r_flush_pending) begin
                    w_flush_pending_next = 1'b1;
                    w_state_next = (w_count_packed != '0) ? ST_EMIT : ST_DONE;
                end
            end
            ST_EMIT: begin
                if (flush_req) w_flush_pending_next = 1'b1;
                if (frame_ready) begin
                    w_buffer_next = '0;
                    w_count_next  = '0;
                    // A flush arriving on the accept cycle still ends the test.
                    w_state_next  = w_flush_pending_next ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_ACCUM;
            r_buffer        <= '0;
            r_count         <= '0;
            r_flush_pending <= 1'b0;
            r_test_ending   <= 1'b0;
            r_err_reserved  <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_buffer        <= w_buffer_next;
            r_count         <= w_count_next;
            r_flush_pending <= w_flush_pending_next;
            r_test_ending   <= w_flush_pending_next && (w_state_next != ST_DONE);
            r_err_reserved  <= w_err_next;
        end
    end

    // Buffer and count are frozen while in EMIT, so the frame is stable
    // until the consumer takes it.
    assign br_stall       = (r_state != ST_ACCUM);
    assign frame_valid    = (r_state == ST_EMIT);
    assign frame_data     = {r_count, r_buffer};
    assign dct_buffer     = r_buffer;
    assign dct_count      = r_count;
    assign test_ending    = r_test_ending;
    assign test_has_ended = (r_state == ST_DONE);
    assign err_reserved   = r_err_reserved;

endmodule

// File: tb/tb_nios2_oci_dct_sequencer.sv
module tb_nios2_oci_dct_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_valid;
    logic [1:0]  br_code;
    logic        br_stall;
    logic        flush_req;
    logic        frame_valid;
    logic        frame_ready;
    logic [33:0] frame_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic        err_reserved;

    always #5 clk = ~clk;

    nios2_oci_dct_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .br_valid       (br_valid),
        .br_code        (br_code),
        .br_stall       (br_stall),
        .flush_req      (flush_req),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .frame_data     (frame_data),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .err_reserved   (err_reserved)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned n_frames = 0;

    // Reference model: accepted codes in arrival order plus a few flags.
    int q[$];
    bit m_emit, m_done, m_pending, m_err;

    function automatic logic [29:0] m_pack();
        logic [29:0] p = '0;
        foreach (q[i]) p[2*i +: 2] = 2'(q[i]);
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("br_stall",       64'(br_stall),       64'(m_emit || m_done));
        check("frame_valid",    64'(frame_valid),    64'(m_emit));
        if (m_emit)
            check("frame_data", 64'(frame_data),     64'({4'(q.size()), m_pack()}));
        check("dct_count",      64'(dct_count),      64'(q.size()));
        check("dct_buffer",     64'(dct_buffer),     64'(m_pack()));
        check("test_ending",    64'(test_ending),    64'(m_pending && !m_done));
        check("test_has_ended", 64'(test_has_ended), 64'(m_done));
        check("err_reserved",   64'(err_reserved),   64'(m_err));
    endtask

    // Called at a negedge: drives one cycle of inputs, advances the model on
    // the rising edge, and compares all outputs at the following negedge.
    task automatic step(input bit v, input bit [1:0] c, input bit f, input bit r, input bit rst);
        br_valid = v; br_code = c; flush_req = f; frame_ready = r; reset = rst;
        @(posedge clk);
        if (rst) begin
            q.delete(); m_emit = 0; m_done = 0; m_pending = 0; m_err = 0;
        end else if (m_done) begin
            // DONE ignores everything until reset
        end else if (m_emit) begin
            if (f) m_pending = 1;
            if (r) begin
                n_frames++;
                q.delete();
                m_emit = 0;
                if (m_pending) m_done = 1;
            end
        end else begin
            if (v) begin
                q.push_back(int'(c));
                if (c == 2'b11) m_err = 1;
            end
            if (q.size() == 15) begin
                m_emit = 1;
                if (f) m_pending = 1;
            end else if (f || m_pending) begin
                m_pending = 1;
                if (q.size() > 0) m_emit = 1;
                else m_done = 1;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [33:0] exp_frame;
        int cycles;
        br_valid = 0; br_code = 0; flush_req = 0; frame_ready = 0; reset = 1;
        @(negedge clk);

        // Reset state
        step(0, 0, 0, 0, 1);
        check("rst_frame_data", 64'(frame_data), 64'd0);

        // 1: full frame of alternating 01/00, zero-stall accept
        for (int i = 0; i < 15; i++) step(1, (i % 2 == 0) ? 2'b01 : 2'b00, 0, 1, 0);
        exp_frame = {4'hF, 30'h11111111};
        check("t1_frame", 64'(frame_data), 64'(exp_frame));
        check("t1_stall", 64'(br_stall), 64'd1);
        step(1, 2'b01, 0, 1, 0);
        check("t1_stall_end", 64'(br_stall), 64'd0);
        check("t1_count0", 64'(dct_count), 64'd0);
        step(1, 2'b01, 0, 1, 0);
        check("t1_next_entry", 64'(dct_count), 64'd1);

        // 2: partial flush, then sticky DONE
        step(0, 0, 0, 0, 1);
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        exp_frame = {4'h3, 30'h00000019};
        check("t2_frame", 64'(frame_data), 64'(exp_frame));
        check("t2_ending", 64'(test_ending), 64'd1);
        step(0, 0, 0, 1, 0);
        check("t2_ended", 64'(test_has_ended), 64'd1);
        step(1, 2'b01, 1, 1, 0);
        check("t2_ignored", 64'(dct_count), 64'd0);

        // 3: consumer back-pressure for 5 cycles with a held code
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) step(1, 2'(i), 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 2'b10, 0, 0, 0);
        check("t3_held_valid", 64'(frame_valid), 64'd1);
        step(1, 2'b10, 0, 1, 0);
        step(1, 2'b10, 0, 0, 0);
        check("t3_entry0", 64'(dct_buffer), 64'd2);

        // 4: flush with empty buffer
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        check("t4_done", 64'(test_has_ended), 64'd1);
        check("t4_no_frame", 64'(frame_valid), 64'd0);

        // 5: 15th code coincides with flush
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 14; i++) step(1, 2'b01, 0, 0, 0);
        step(1, 2'b01, 1, 0, 0);
        check("t5_full_count", 64'(frame_data[33:30]), 64'hF);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("t5_no_second", 64'(frame_valid), 64'd0);

        // 6: reserved code, then reset while a frame is held
        step(0, 0, 0, 0, 1);
        step(1, 2'b11, 0, 0, 0);
        check("t6_err", 64'(err_reserved), 64'd1);
        check("t6_packed", 64'(dct_buffer), 64'd3);
        for (int i = 0; i < 14; i++) step(1, 2'b00, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("t6_rst_valid", 64'(frame_valid), 64'd0);
        check("t6_rst_err", 64'(err_reserved), 64'd0);

        // Random traffic
        cycles = 0;
        while (cycles < 4000) begin
            bit rst;
            rst = m_done ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 79) == 0,
                 $urandom_range(0, 1) == 1, rst);
            cycles++;
        end
        check("rand_frames_seen", 64'(n_frames > 20), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
